// File: rtl/fma16_dot_if.sv
// ============================================================================
// Module : fma16_dot_if
// Brief  : Job, element, fma16-datapath and result signals of fma16_dot.
//          FMA16_DOT_ABORT_EN adds the abort input.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fma16_dot_if;
  logic        start;
  logic [3:0]  len;
  logic [1:0]  roundmode;
  logic        elem_valid;
  logic        elem_ready;
  logic [15:0] ex;
  logic [15:0] ey;
  logic [15:0] fma_x;
  logic [15:0] fma_y;
  logic [15:0] fma_z;
  logic        fma_mul;
  logic        fma_add;
  logic        fma_negp;
  logic        fma_negz;
  logic [1:0]  fma_roundmode;
  logic [15:0] fma_result;
  logic [3:0]  fma_flags;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] acc;
  logic [3:0]  acc_flags;
  logic        busy;
`ifdef FMA16_DOT_ABORT_EN
  logic        abort;

  modport slave (
    input  start, len, roundmode, elem_valid, ex, ey, fma_result, fma_flags,
           res_ready, abort,
    output elem_ready, fma_x, fma_y, fma_z, fma_mul, fma_add, fma_negp,
           fma_negz, fma_roundmode, res_valid, acc, acc_flags, busy
  );

  modport master (
    output start, len, roundmode, elem_valid, ex, ey, fma_result, fma_flags,
           res_ready, abort,
    input  elem_ready, fma_x, fma_y, fma_z, fma_mul, fma_add, fma_negp,
           fma_negz, fma_roundmode, res_valid, acc, acc_flags, busy
  );
`else
  modport slave (
    input  start, len, roundmode, elem_valid, ex, ey, fma_result, fma_flags,
           res_ready,
    output elem_ready, fma_x, fma_y, fma_z, fma_mul, fma_add, fma_negp,
           fma_negz, fma_roundmode, res_valid, acc, acc_flags, busy
  );

  modport master (
    output start, len, roundmode, elem_valid, ex, ey, fma_result, fma_flags,
           res_ready,
    input  elem_ready, fma_x, fma_y, fma_z, fma_mul, fma_add, fma_negp,
           fma_negz, fma_roundmode, res_valid, acc, acc_flags, busy
  );
`endif

endinterface

`default_nettype wire

// File: rtl/fma16_dot.sv
// ============================================================================
// Module : fma16_dot
// Brief  : FP16 dot-product sequencer around an external combinational fma16.
//          FMA16_DOT_ABORT_EN adds an abort input that cancels a running job.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fma16_dot (
  input  logic       clk,
  input  logic       reset_n,
  fma16_dot_if.slave dot_if
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [15:0] c_FP16_ZERO = 16'h0000;

  state_t      state_q, state_d;
  logic [15:0] acc_q,   acc_d;
  logic [3:0]  flags_q, flags_d;
  logic [3:0]  count_q, count_d;
  logic [1:0]  rm_q,    rm_d;
  logic        w_accept;
  logic        w_abort;

`ifdef FMA16_DOT_ABORT_EN
  assign w_abort = dot_if.abort && (state_q != ST_IDLE);
`else
  assign w_abort = 1'b0;
`endif

  assign w_accept = (state_q == ST_RUN) && dot_if.elem_valid;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      acc_q   <= c_FP16_ZERO;
      flags_q <= 4'd0;
      count_q <= 4'd0;
      rm_q    <= 2'd0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      flags_q <= flags_d;
      count_q <= count_d;
      rm_q    <= rm_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    flags_d = flags_q;
    count_d = count_q;
    rm_d    = rm_q;

    unique case (state_q)
      ST_IDLE: begin
        if (dot_if.start) begin
          acc_d   = c_FP16_ZERO;
          flags_d = 4'd0;
          count_d = dot_if.len;
          rm_d    = dot_if.roundmode;
          state_d = (dot_if.len == 4'd0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_accept) begin
          acc_d   = dot_if.fma_result;
          flags_d = flags_q | dot_if.fma_flags;
          count_d = count_q - 4'd1;
          if (count_q == 4'd1) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (dot_if.res_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort outranks any accept or hand-off decided above.
    if (w_abort) begin
      state_d = ST_IDLE;
      acc_d   = c_FP16_ZERO;
      flags_d = 4'd0;
      count_d = 4'd0;
    end
  end

  assign dot_if.elem_ready    = (state_q == ST_RUN);
  assign dot_if.res_valid     = (state_q == ST_DONE);
  assign dot_if.busy          = (state_q != ST_IDLE);
  assign dot_if.acc           = acc_q;
  assign dot_if.acc_flags     = flags_q;
  assign dot_if.fma_x         = dot_if.ex;
  assign dot_if.fma_y         = dot_if.ey;
  assign dot_if.fma_z         = acc_q;
  assign dot_if.fma_mul       = 1'b1;
  assign dot_if.fma_add       = 1'b1;
  assign dot_if.fma_negp      = 1'b0;
  assign dot_if.fma_negz      = 1'b0;
  assign dot_if.fma_roundmode = rm_q;

endmodule

`default_nettype wire

// File: tb/tb_fma16_dot.sv
// ============================================================================
// Module : tb_fma16_dot
// Brief  : Self-checking bench for fma16_dot with a real-arithmetic fma16
//          model; FMA16_DOT_ABORT_EN enables the abort scenarios.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fma16_dot;

  logic clk;
  logic reset_n;
  logic chk_en;
  int   n_chk;
  int   n_fail;

  fma16_dot_if dif ();

  fma16_dot dut (
    .clk     (clk),
    .reset_n (reset_n),
    .dot_if  (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flag layout of the fma16 model: {invalid, overflow, underflow, inexact}.
  function automatic real f2r(input logic [15:0] h);
    real v;
    int  e;
    e = int'(h[14:10]);
    if (e == 31)     v = 1.0e300;
    else if (e == 0) v = real'(h[9:0]) * (2.0 ** (-24));
    else             v = real'({1'b1, h[9:0]}) * (2.0 ** (e - 25));
    return h[15] ? -v : v;
  endfunction

  function automatic logic [19:0] r2f(input real v);
    logic       s;
    logic       sub;
    real        a, m, fr;
    int         e, q;
    logic [3:0] fl;
    s  = (v < 0.0);
    a  = s ? -v : v;
    fl = 4'b0000;
    if (a != a)        return {4'b1000, 16'h7E00};
    if (a == 0.0)      return {4'b0000, s, 15'h0000};
    if (a >= 65520.0)  return {4'b0101, s, 15'h7C00};
    e = 0;
    m = a;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0)  begin m = m * 2.0; e--; end
    sub = (e < -14);
    m   = sub ? a * (2.0 ** 24) : m * 1024.0;
    q   = $rtoi(m);
    fr  = m - real'(q);
    if (fr != 0.0) fl[0] = 1'b1;
    if (fr > 0.5 || (fr == 0.5 && (q % 2) == 1)) q++;
    if (sub) begin
      if (fl[0]) fl[1] = 1'b1;
      return {fl, s, q[14:0]};
    end
    if (q == 2048) begin q = 1024; e++; end
    if (e > 15) return {4'b0101, s, 15'h7C00};
    return {fl, s, 5'(e + 15), q[9:0]};
  endfunction

  function automatic logic [19:0] fp_fma(input logic [15:0] x, input logic [15:0] y,
                                         input logic [15:0] z);
    return r2f(f2r(x) * f2r(y) + f2r(z));
  endfunction

  function automatic logic [15:0] fma_res(input logic [15:0] x, input logic [15:0] y,
                                          input logic [15:0] z);
    logic [19:0] r;
    r = fp_fma(x, y, z);
    return r[15:0];
  endfunction

  function automatic logic [3:0] fma_flg(input logic [15:0] x, input logic [15:0] y,
                                         input logic [15:0] z);
    logic [19:0] r;
    r = fp_fma(x, y, z);
    return r[19:16];
  endfunction

  // External fma16 datapath stand-in.
  always_comb begin
    dif.fma_result = fma_res(dif.fma_x, dif.fma_y, dif.fma_z);
    dif.fma_flags  = fma_flg(dif.fma_x, dif.fma_y, dif.fma_z);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Job-level reference: phase 0 idle, 1 collecting elements, 2 result held.
  int          m_phase;
  int          m_left;
  logic [15:0] m_acc;
  logic [3:0]  m_flags;
  logic [1:0]  m_rm;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_phase <= 0;
      m_left  <= 0;
      m_acc   <= 16'h0000;
      m_flags <= 4'h0;
      m_rm    <= 2'd0;
    end
`ifdef FMA16_DOT_ABORT_EN
    else if (dif.abort && m_phase != 0) begin
      m_phase <= 0;
      m_left  <= 0;
      m_acc   <= 16'h0000;
      m_flags <= 4'h0;
    end
`endif
    else if (m_phase == 0) begin
      if (dif.start) begin
        m_acc   <= 16'h0000;
        m_flags <= 4'h0;
        m_rm    <= dif.roundmode;
        m_left  <= int'(dif.len);
        m_phase <= (dif.len == 4'd0) ? 2 : 1;
      end
    end else if (m_phase == 1) begin
      if (dif.elem_valid) begin
        m_acc   <= fma_res(dif.ex, dif.ey, m_acc);
        m_flags <= m_flags | fma_flg(dif.ex, dif.ey, m_acc);
        m_left  <= m_left - 1;
        if (m_left == 1) m_phase <= 2;
      end
    end else begin
      if (dif.res_ready) m_phase <= 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("elem_ready", 32'(dif.elem_ready), 32'(m_phase == 1));
      chk("res_valid",  32'(dif.res_valid),  32'(m_phase == 2));
      chk("busy",       32'(dif.busy),       32'(m_phase != 0));
      chk("acc",        32'(dif.acc),        32'(m_acc));
      chk("acc_flags",  32'(dif.acc_flags),  32'(m_flags));
      chk("fma_x",      32'(dif.fma_x),      32'(dif.ex));
      chk("fma_y",      32'(dif.fma_y),      32'(dif.ey));
      chk("fma_z",      32'(dif.fma_z),      32'(m_acc));
      chk("fma_ctl",    32'({dif.fma_mul, dif.fma_add, dif.fma_negp, dif.fma_negz}), 32'h0000_000C);
      chk("fma_rm",     32'(dif.fma_roundmode), 32'(m_rm));
    end
  end

  logic [15:0] vx [0:15];
  logic [15:0] vy [0:15];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one job; gap idle cycles separate consecutive elements, and start
  // pulses with a different len/roundmode are driven during those gaps.
  task automatic job(input int n, input logic [1:0] rm, input int gap, output int lat);
    int idx;
    int g;
    idx = 0;
    g   = 0;
    dif.start     = 1'b1;
    dif.len       = 4'(n);
    dif.roundmode = rm;
    step();
    dif.start = 1'b0;
    lat = 1;
    while (!dif.res_valid && lat < 64) begin
      if (dif.elem_ready && idx < n && g == 0) begin
        dif.start      = 1'b0;
        dif.elem_valid = 1'b1;
        dif.ex         = vx[idx];
        dif.ey         = vy[idx];
        idx++;
        g = gap;
      end else begin
        dif.elem_valid = 1'b0;
        dif.ex         = 16'h5555;
        dif.ey         = 16'h5555;
        dif.start      = 1'b1;
        dif.len        = 4'hF;
        dif.roundmode  = ~rm;
        if (g > 0) g--;
      end
      step();
      lat++;
    end
    dif.elem_valid = 1'b0;
    dif.start      = 1'b0;
  endtask

  task automatic take();
    dif.res_ready = 1'b1;
    step();
    dif.res_ready = 1'b0;
    chk("idle_after_take", 32'(dif.busy), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    n_chk  = 0;
    n_fail = 0;
    chk_en = 1'b0;
    reset_n        = 1'b0;
    dif.start      = 1'b0;
    dif.len        = 4'd0;
    dif.roundmode  = 2'd0;
    dif.elem_valid = 1'b0;
    dif.ex         = 16'h0000;
    dif.ey         = 16'h0000;
    dif.res_ready  = 1'b0;
`ifdef FMA16_DOT_ABORT_EN
    dif.abort      = 1'b0;
`endif
    step();
    chk_en = 1'b1;
    step();
    chk("rst_res_valid",  32'(dif.res_valid),  32'h0);
    chk("rst_elem_ready", 32'(dif.elem_ready), 32'h0);
    chk("rst_busy",       32'(dif.busy),       32'h0);
    chk("rst_acc",        32'(dif.acc),        32'h0);
    chk("rst_flags",      32'(dif.acc_flags),  32'h0);
    chk("rst_rm",         32'(dif.fma_roundmode), 32'h0);
    reset_n = 1'b1;

    // 1*2 + 2*3 = 8.0, back-to-back
    vx[0] = 16'h3C00; vy[0] = 16'h4000;
    vx[1] = 16'h4000; vy[1] = 16'h4200;
    job(2, 2'd0, 0, lat);
    chk("A_latency", 32'(lat),           32'd3);
    chk("A_acc",     32'(dif.acc),       32'h4800);
    chk("A_flags",   32'(dif.acc_flags), 32'h0);
    take();
    step();
    chk("A_idle_hold", 32'(dif.acc), 32'h4800);

    // same job with 3 idle cycles between elements
    job(2, 2'd1, 3, lat);
    chk("B_latency", 32'(lat),     32'd6);
    chk("B_acc",     32'(dif.acc), 32'h4800);
    take();

    // empty job, result held while consumer stalls
    job(0, 2'd2, 0, lat);
    chk("C_latency", 32'(lat),     32'd1);
    chk("C_acc",     32'(dif.acc), 32'h0);
    for (int i = 0; i < 4; i++) begin
      dif.start = 1'b1;
      dif.len   = 4'd2;
      step();
      chk("C_hold_valid", 32'(dif.res_valid), 32'h1);
      chk("C_hold_acc",   32'(dif.acc),       32'h0);
    end
    dif.start = 1'b0;
    take();

    // overflow to +inf, then a clean job clears the sticky flags
    vx[0] = 16'h7BFF; vy[0] = 16'h7BFF;
    job(1, 2'd0, 0, lat);
    chk("D_latency", 32'(lat),           32'd2);
    chk("D_acc",     32'(dif.acc),       32'h7C00);
    chk("D_flags",   32'(dif.acc_flags), 32'h5);
    take();
    vx[0] = 16'h3C00; vy[0] = 16'h3C00;
    job(1, 2'd0, 0, lat);
    chk("E_acc",   32'(dif.acc),       32'h3C00);
    chk("E_flags", 32'(dif.acc_flags), 32'h0);
    take();

    // inexact, negative and subnormal operands
    vx[0] = 16'h3555; vy[0] = 16'h3555;
    vx[1] = 16'hC000; vy[1] = 16'h3800;
    vx[2] = 16'h0001; vy[2] = 16'h3C00;
    job(3, 2'd3, 0, lat);
    chk("F_latency", 32'(lat), 32'd4);
    take();

    // reset after the first of three elements
    dif.start = 1'b1; dif.len = 4'd3; dif.roundmode = 2'd1;
    step();
    dif.start = 1'b0;
    dif.elem_valid = 1'b1; dif.ex = 16'h4000; dif.ey = 16'h4000;
    step();
    reset_n = 1'b0;
    dif.ex = 16'h3C00; dif.ey = 16'h3C00;
    step();
    reset_n = 1'b1;
    dif.elem_valid = 1'b0;
    chk("R_acc",        32'(dif.acc),        32'h0);
    chk("R_elem_ready", 32'(dif.elem_ready), 32'h0);
    chk("R_busy",       32'(dif.busy),       32'h0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("R_no_result", 32'(dif.res_valid), 32'h0);
    end

`ifdef FMA16_DOT_ABORT_EN
    // abort beats a simultaneous element accept
    dif.start = 1'b1; dif.len = 4'd3; dif.roundmode = 2'd0;
    step();
    dif.start = 1'b0;
    dif.elem_valid = 1'b1; dif.ex = 16'h4000; dif.ey = 16'h4000;
    step();
    dif.abort = 1'b1;
    dif.ex = 16'h3C00; dif.ey = 16'h3C00;
    step();
    dif.abort = 1'b0;
    dif.elem_valid = 1'b0;
    chk("X_busy", 32'(dif.busy), 32'h0);
    chk("X_acc",  32'(dif.acc),  32'h0);

    // abort beats res_ready in DONE
    job(0, 2'd0, 0, lat);
    dif.abort = 1'b1; dif.res_ready = 1'b1;
    step();
    dif.abort = 1'b0; dif.res_ready = 1'b0;
    chk("X_done_abort", 32'(dif.res_valid), 32'h0);

    // abort in IDLE leaves the last result alone
    vx[0] = 16'h3C00; vy[0] = 16'h3C00;
    job(1, 2'd0, 0, lat);
    take();
    dif.abort = 1'b1;
    step();
    dif.abort = 1'b0;
    chk("X_idle_abort", 32'(dif.acc), 32'h3C00);
`endif

    step();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fma16_dot.md
FMA16_DOT -- requirements
Module: fma16_dot

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  synchronous active-low reset.
REQ-004 start  input  1  begin a dot-product job; sampled only in IDLE.
REQ-005 len  input  4  element count, sampled with start; 0..15.
REQ-006 roundmode  input  2  rounding mode, latched with start.
REQ-007 elem_valid  input  1  element pair ex/ey present.
REQ-008 elem_ready  output  1  block accepts an element this cycle.
REQ-009 ex, ey  input  16 each  FP16 element operands.
REQ-010 fma_x, fma_y, fma_z  output  16 each  operands to the fma16 datapath.
REQ-011 fma_mul, fma_add, fma_negp, fma_negz  output  1 each  fma16 op controls.
REQ-012 fma_roundmode  output  2  latched roundmode.
REQ-013 fma_result  input  16  fma16 result, combinational from fma_* in the same cycle.
REQ-014 fma_flags  input  4  fma16 flags, same cycle.
REQ-015 res_valid  output  1  acc and acc_flags hold a finished job.
REQ-016 res_ready  input  1  consumer takes the result.
REQ-017 acc  output  16  FP16 accumulator.
REQ-018 acc_flags  output  4  sticky OR of fma_flags over the job.
REQ-019 busy  output  1  high in RUN or DONE.

Function
REQ-020 The FSM SHALL have the states IDLE, RUN and DONE.
REQ-021 IDLE: on start with len!=0, go to RUN, set acc=0x0000, acc_flags=0, count=len, and latch roundmode.
REQ-022 IDLE: on start with len==0, go directly to DONE with acc=0x0000 and acc_flags=0.
REQ-023 elem_ready SHALL be 1 only in RUN.
REQ-024 fma_x=ex, fma_y=ey, fma_z=acc, fma_mul=1, fma_add=1, fma_negp=0, fma_negz=0 at all times.
REQ-025 RUN: on elem_valid&&elem_ready, set acc<=fma_result, acc_flags<=acc_flags|fma_flags, and count<=count-1.
REQ-026 RUN: the accept that takes count from 1 to 0 SHALL move to DONE; one element accepted per cycle max, zero-bubble.
REQ-027 RUN with elem_valid=0: state, acc and count SHALL hold.
REQ-028 DONE: res_valid=1 and acc/acc_flags SHALL be stable; res_valid&&res_ready returns to IDLE next cycle.
REQ-029 start outside IDLE SHALL be ignored; len/roundmode changes outside IDLE SHALL have no effect.
REQ-030 Latency SHALL be len+1 cycles from start to res_valid for a continuously valid source; for len==0 it SHALL be 1 cycle.
REQ-031 acc and acc_flags SHALL hold their last value in IDLE until the next start.

Reset
REQ-032 On reset_n=0 at a clock edge: state=IDLE, acc=0x0000, acc_flags=0, count=0, latched roundmode=0, res_valid=0, elem_ready=0, busy=0.
REQ-033 Reset mid-RUN or mid-DONE SHALL abandon the job; no res_valid afterwards.

Configuration
REQ-034 Macro FMA16_DOT_ABORT_EN SHALL add input abort (1 bit).
REQ-035 With FMA16_DOT_ABORT_EN defined: abort=1 in RUN or DONE returns to IDLE next cycle; acc and acc_flags are cleared to 0; no res_valid; abort has priority over an element accept or res_ready in the same cycle; abort in IDLE is ignored.
REQ-036 Without FMA16_DOT_ABORT_EN: no abort port; behaviour is per REQ-020..031.

Verification
REQ-037 start, len=2, rm=0; elements (0x3C00,0x4000), (0x4000,0x4200) back-to-back -> res_valid at cycle 3, acc=0x4800, acc_flags=0.
REQ-038 Same job with elem_valid low for 3 cycles between elements -> acc=0x4800, res_valid 3 cycles later, count held.
REQ-039 start, len=0 -> res_valid the next cycle, acc=0x0000; hold res_ready=0 for 4 cycles -> res_valid and acc stable, start pulses ignored.
REQ-040 len=1, (0x7BFF,0x7BFF) -> acc=0x7C00 (RNE), acc_flags overflow and inexact set; the next job starts with acc_flags=0.
REQ-041 reset_n=0 mid-RUN after 1 of 3 elements -> IDLE, acc=0x0000, elem_ready=0, no res_valid.
REQ-042 With FMA16_DOT_ABORT_EN: abort with elem_valid in the same cycle in RUN -> IDLE, acc unchanged by the element and cleared to 0x0000.
